// File: rtl/disp_page_sched.sv
// Three-page display scheduler: rotates requesting pages with a dwell timer and forced advance.
// Define DISP_PAGE_SCHED_BLANK_EN to insert a dark BLANK_CYCLES gap between different pages.
module disp_page_sched #(
  parameter logic [31:0] DWELL_CYCLES = 32'd200000000,
  parameter logic [31:0] BLANK_CYCLES = 32'd10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  page_req,
  input  logic [31:0] page0_data,
  input  logic [31:0] page1_data,
  input  logic [31:0] page2_data,
  input  logic        next_pulse,
  output logic [31:0] display_out,
  output logic        display_en_out,
  output logic [2:0]  grant
);

`ifdef DISP_PAGE_SCHED_BLANK_EN
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHOW} state_t;
`endif

  state_t      state;
  logic [1:0]  cur;
  logic [31:0] timer;

  function automatic logic [2:0] onehot(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [1:0] lowest_req(input logic [2:0] req);
    if (req[0])      return 2'd0;
    else if (req[1]) return 2'd1;
    else             return 2'd2;
  endfunction

  // Cyclic search starting after c; falls back to c itself when it is the only requester.
  function automatic logic [1:0] next_req(input logic [2:0] req, input logic [1:0] c);
    logic [1:0] res;
    int         idx;
    res = c;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(c) + k) % 3;
      if (req[idx]) res = 2'(idx);
    end
    return res;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] c, input logic [31:0] d0,
                                       input logic [31:0] d1, input logic [31:0] d2);
    case (c)
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d0;
    endcase
  endfunction

  logic        others;
  logic        dwell_done;
  logic        leave;
  logic        restart;
  logic [1:0]  low_page;
  logic [1:0]  nxt_page;
  logic [31:0] low_data;
  logic [31:0] nxt_data;
  logic [31:0] cur_data;

  always_comb begin
    others     = |(page_req & ~onehot(cur));
    dwell_done = (timer == DWELL_CYCLES - 32'd1);
    // Leaving only makes sense when someone else is waiting; a dropped own request implies that.
    leave      = others && (!page_req[cur] || next_pulse || dwell_done);
    restart    = dwell_done || next_pulse;
    low_page   = lowest_req(page_req);
    nxt_page   = next_req(page_req, cur);
    low_data   = pick(low_page, page0_data, page1_data, page2_data);
    nxt_data   = pick(nxt_page, page0_data, page1_data, page2_data);
    cur_data   = pick(cur, page0_data, page1_data, page2_data);
  end

`ifdef DISP_PAGE_SCHED_BLANK_EN
  logic blank_done;
  assign blank_done = (timer == BLANK_CYCLES - 32'd1);
`else
  logic unused_blank;
  assign unused_blank = ^BLANK_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cur            <= 2'd0;
      timer          <= 32'd0;
      display_out    <= 32'd0;
      display_en_out <= 1'b0;
      grant          <= 3'b000;
    end else if (page_req == 3'b000) begin
      state          <= IDLE;
      timer          <= 32'd0;
      display_out    <= 32'd0;
      display_en_out <= 1'b0;
      grant          <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          state          <= SHOW;
          cur            <= low_page;
          timer          <= 32'd0;
          grant          <= onehot(low_page);
          display_en_out <= 1'b1;
          display_out    <= low_data;
        end
        SHOW: begin
          if (leave) begin
`ifdef DISP_PAGE_SCHED_BLANK_EN
            state          <= BLANK;
            timer          <= 32'd0;
            grant          <= 3'b000;
            display_en_out <= 1'b0;
`else
            cur            <= nxt_page;
            timer          <= 32'd0;
            grant          <= onehot(nxt_page);
            display_en_out <= 1'b1;
            display_out    <= nxt_data;
`endif
          end else begin
            timer          <= restart ? 32'd0 : timer + 32'd1;
            grant          <= onehot(cur);
            display_en_out <= 1'b1;
            display_out    <= cur_data;
          end
        end
`ifdef DISP_PAGE_SCHED_BLANK_EN
        BLANK: begin
          if (blank_done) begin
            state          <= SHOW;
            cur            <= nxt_page;
            timer          <= 32'd0;
            grant          <= onehot(nxt_page);
            display_en_out <= 1'b1;
            display_out    <= nxt_data;
          end else begin
            timer <= timer + 32'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_page_sched.sv
// Randomized scoreboard bench for disp_page_sched against a countdown-based page rotation model.
module tb_disp_page_sched;
  localparam int DWELL = 10;
  localparam int BLANK = 3;
`ifdef DISP_PAGE_SCHED_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  page_req;
  logic [31:0] page0_data, page1_data, page2_data;
  logic        next_pulse;
  logic [31:0] display_out;
  logic        display_en_out;
  logic [2:0]  grant;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]  g;
    logic        en;
    logic [31:0] d;
  } exp_t;
  exp_t expq[$];

  logic [31:0] pd[3];
  int          m_mode;   // 0 dark, 1 showing, 2 blanking
  int          m_page;
  int          m_left;   // cycles left in the current phase, including this one
  logic [31:0] m_disp;

  always #5 clk = ~clk;

  disp_page_sched #(
    .DWELL_CYCLES(32'd10),
    .BLANK_CYCLES(32'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .page_req(page_req),
    .page0_data(page0_data),
    .page1_data(page1_data),
    .page2_data(page2_data),
    .next_pulse(next_pulse),
    .display_out(display_out),
    .display_en_out(display_en_out),
    .grant(grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int lowest(input logic [2:0] req);
    for (int k = 0; k < 3; k++) if (req[k]) return k;
    return 0;
  endfunction

  function automatic int next_after(input logic [2:0] req, input int p);
    for (int k = 1; k <= 3; k++) if (req[(p + k) % 3]) return (p + k) % 3;
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_page = 0;
    m_left = 0;
    m_disp = 32'd0;
  endtask

  task automatic enter_show();
    m_mode = 1;
    m_left = DWELL;
    m_disp = pd[m_page];
  endtask

  task automatic model_step();
    bit others;
    if (page_req == 3'b000) begin
      m_mode = 0;
      m_disp = 32'd0;
    end else if (m_mode == 0) begin
      m_page = lowest(page_req);
      enter_show();
    end else if (m_mode == 1) begin
      others = (page_req & ~(3'b001 << m_page)) != 3'b000;
      if (others && (!page_req[m_page] || next_pulse || m_left == 1)) begin
        if (BLANK_ON) begin
          m_mode = 2;
          m_left = BLANK;
        end else begin
          m_page = next_after(page_req, m_page);
          enter_show();
        end
      end else begin
        m_left = (next_pulse || m_left == 1) ? DWELL : m_left - 1;
        m_disp = pd[m_page];
      end
    end else begin
      if (m_left == 1) begin
        m_page = next_after(page_req, m_page);
        enter_show();
      end else begin
        m_left--;
      end
    end
  endtask

  task automatic drive_push(input logic [2:0] req, input logic np, input bit rnd);
    logic [2:0] eg;
    page_req   = req;
    next_pulse = np;
    if (rnd) for (int i = 0; i < 3; i++) if ($urandom_range(0, 2) == 0) pd[i] = $urandom;
    page0_data = pd[0];
    page1_data = pd[1];
    page2_data = pd[2];
    model_step();
    eg = (m_mode == 1) ? 3'(3'b001 << m_page) : 3'b000;
    expq.push_back('{g: eg, en: (m_mode == 1), d: m_disp});
  endtask

  task automatic cyc(input logic [2:0] req, input logic np, input bit rnd);
    @(negedge clk);
    drive_push(req, np, rnd);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_en", 32'(display_en_out), 32'd0);
    check("async_rst_disp", display_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_push(page_req, 1'b0, 1'b1);
  endtask

  // Monitor: compares every post-edge output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("grant", 32'(grant), 32'(e.g));
        check("display_en", 32'(display_en_out), 32'(e.en));
        check("display_out", display_out, e.d);
        check("grant_onehot_en", 32'($onehot0(grant) && ((grant != 3'b000) == display_en_out)), 32'd1);
      end
    end
  end

  initial begin
    logic [2:0] req;
    rst        = 1'b1;
    page_req   = 3'b000;
    next_pulse = 1'b0;
    for (int i = 0; i < 3; i++) pd[i] = 32'd0;
    page0_data = 32'd0;
    page1_data = 32'd0;
    page2_data = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_en", 32'(display_en_out), 32'd0);
    check("reset_disp", display_out, 32'd0);
    rst = 1'b0;
    model_reset();
    drive_push(3'b000, 1'b0, 1'b0);

    repeat (15) cyc(3'b000, 1'b0, 1'b1);

    pd[0] = 32'h50000001;
    pd[1] = 32'h12345678;
    pd[2] = 32'h50000030;
    repeat (45) cyc(3'b101, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) cyc(3'b010, (i % 7) == 3, 1'b1);

    repeat (2) cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b011, 1'b0, 1'b1);
    cyc(3'b011, 1'b0, 1'b1);
    cyc(3'b011, 1'b0, 1'b1);
    cyc(3'b011, 1'b1, 1'b1);
    repeat (10) cyc(3'b011, 1'b0, 1'b1);

    repeat (2) cyc(3'b000, 1'b0, 1'b1);
    repeat (11) cyc(3'b101, 1'b0, 1'b1);
    repeat (3) cyc(3'b000, 1'b0, 1'b1);

    repeat (5) cyc(3'b010, 1'b0, 1'b1);
    reset_mid();
    repeat (40) cyc(3'b111, 1'b0, 1'b1);
    repeat (12) cyc(3'b101, 1'b0, 1'b1);
    reset_mid();

    req = 3'b011;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) req = 3'($urandom_range(0, 7));
      if (i == 700) reset_mid();
      else cyc(req, $urandom_range(0, 11) == 0, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/disp_page_sched.md
DISP_PAGE_SCHED -- requirements
Module: disp_page_sched

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 200000000, clock cycles one page is shown (2 s at 100 MHz), legal range 1..2^32-1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 10000000, clock cycles of blanking between pages (100 ms), legal range 1..2^32-1.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port page_req  input  3  per-page display request, bit i = page i wants the display.
REQ-006 SHALL have ports page0_data, page1_data, page2_data  input  32 each  8-digit BCD page contents, [31:28] = DK7 ... [3:0] = DK0.
REQ-007 SHALL have port next_pulse  input  1  one-cycle debounced pulse that forces advance to the next page.
REQ-008 SHALL have port display_out  output  32  page data for the digit-scan unit.
REQ-009 SHALL have port display_en_out  output  1  display enable for the digit-scan unit, high = digits lit.
REQ-010 SHALL have port grant  output  3  one-hot granted page, all zero when no page is shown.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHOW and BLANK, plus a 2-bit current-page register cur and a 32-bit timer.
REQ-012 IDLE: display_out=0, display_en_out=0, grant=0; when page_req!=0, go next cycle to SHOW with cur = lowest set page_req bit and timer=0.
REQ-013 SHOW: grant=onehot(cur), display_en_out=1, display_out = page<cur>_data registered (1-cycle latency from data change); timer increments every cycle.
REQ-014 SHOW, timer reaches DWELL_CYCLES-1 with other pages requesting: go to BLANK, timer=0.
REQ-015 SHOW, timer reaches DWELL_CYCLES-1 with only cur requesting: stay in SHOW, timer=0, no blanking.
REQ-016 SHOW, next_pulse=1 with another page requesting: go to BLANK immediately, abandoning the remaining dwell; with no other page requesting, next_pulse only restarts the timer.
REQ-017 SHOW, page_req[cur] falls while other pages still request: go to BLANK next cycle.
REQ-018 BLANK: display_en_out=0, grant=0, display_out holds its last value; after BLANK_CYCLES cycles, load cur with the next requesting page after cur, searched cyclically 0->1->2->0, then enter SHOW with timer=0.
REQ-019 BLANK, if the only requesting page at exit is the old cur: re-enter SHOW on it.
REQ-020 SHALL go to IDLE on the next cycle from any state when page_req==0; IDLE takes priority over every other transition.
REQ-021 next_pulse in IDLE or BLANK SHALL be ignored.
REQ-022 grant SHALL never have more than one bit set; grant!=0 exactly when state==SHOW.

Reset
REQ-023 While rst=1, SHALL asynchronously force state=IDLE, cur=0, timer=0, display_out=0, display_en_out=0, grant=0.
REQ-024 Reset asserted mid-SHOW or mid-BLANK SHALL abort the page, with no residual timer value after release.
REQ-025 First evaluation after reset release SHALL follow the IDLE rules.

Configuration
REQ-026 Macro DISP_PAGE_SCHED_BLANK_EN defined: the BLANK state and BLANK_CYCLES are implemented as above.
REQ-027 Macro DISP_PAGE_SCHED_BLANK_EN undefined: no BLANK state; every SHOW->BLANK transition instead goes directly SHOW->SHOW on the next cyclic requesting page, timer=0, display_en_out staying 1, and BLANK_CYCLES is ignored.

Verification (DWELL_CYCLES=10, BLANK_CYCLES=3)
REQ-028 Reset, then page_req=3'b000 -> display_en_out=0, grant=0, display_out=0 indefinitely.
REQ-029 page_req=3'b101, page0_data=32'h50000001, page2_data=32'h50000030 -> grant=001 for 10 cycles, 3 cycles with display_en_out=0, then grant=100 for 10 cycles, then back to 001.
REQ-030 page_req=3'b010 only -> grant=010 held continuously and display_en_out never drops.
REQ-031 In SHOW on page 0 with page_req=3'b011, next_pulse at timer=2 -> BLANK next cycle, then grant=010 after 3 blank cycles.
REQ-032 page_req drops to 000 during BLANK -> IDLE next cycle, and rst asserted mid-SHOW -> all outputs 0 immediately, asynchronously.
REQ-033 Build without DISP_PAGE_SCHED_BLANK_EN, page_req=3'b111 -> grant sequence 001, 010, 100, 001, each for 10 cycles with no gap.
